// File: rtl/obi_master.sv
// obi_master -- controller-side OBI manager.
//
// Turns single-beat read/write commands into OBI A-channel transactions and
// hands the R-channel responses back to the controller through a one-entry
// response buffer. Up to MAX_OUTSTANDING granted transactions may be waiting
// for rvalid at once. Responses come back in issue order because OBI
// guarantees in-order responses, so no IDs are tracked.
//
// Ports:
//   clk_i, reset_ni         clock (rising edge), asynchronous active-low reset
//   cmd_valid_i/ready_o     command handshake
//   cmd_addr_i, cmd_we_i,
//   cmd_be_i, cmd_wdata_i   command payload
//   rsp_valid_o/ready_i     response handshake
//   rsp_rdata_o, rsp_err_o  response payload
//   obi_req_o, obi_gnt_i    OBI A-channel handshake
//   obi_addr_o, obi_we_o,
//   obi_be_o, obi_wdata_o   OBI A-channel payload (held stable while req)
//   obi_rvalid_i/rready_o,
//   obi_rdata_i, obi_err_i  OBI R channel
//   busy_o                  request pending, transactions in flight or
//                           response buffered
//   err_count_o             saturating count of accepted error responses
module obi_master #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,

  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic                    cmd_we_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_be_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,

  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,

  output logic                    obi_req_o,
  input  logic                    obi_gnt_i,
  output logic [ADDR_WIDTH-1:0]   obi_addr_o,
  output logic                    obi_we_o,
  output logic [DATA_WIDTH/8-1:0] obi_be_o,
  output logic [DATA_WIDTH-1:0]   obi_wdata_o,

  input  logic                    obi_rvalid_i,
  output logic                    obi_rready_o,
  input  logic [DATA_WIDTH-1:0]   obi_rdata_i,
  input  logic                    obi_err_i,

  output logic                    busy_o,
  output logic [15:0]             err_count_o
);

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  state_t                  state;
  logic [CNT_WIDTH-1:0]    outstanding;
  logic                    req_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    we_q;
  logic [BE_WIDTH-1:0]     be_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  logic                    rbuf_valid;
  logic [DATA_WIDTH-1:0]   rbuf_rdata;
  logic                    rbuf_err;
  logic [15:0]             err_count;

  logic cmd_fire;
  logic gnt_fire;
  logic r_fire;
  logic rsp_deq;

  // Handshake qualifiers; every one of these depends only on registers and
  // the current-cycle inputs, so none of the outputs below are glitchy
  // functions of each other.
  assign cmd_ready_o  = (state == IDLE) && (outstanding < CNT_MAX);
  assign cmd_fire     = cmd_valid_i && cmd_ready_o;
  assign gnt_fire     = (state == REQ) && obi_gnt_i;
  // A response may be taken only for a transaction we actually issued, and
  // only if the buffer is empty or is being drained this same cycle.
  assign obi_rready_o = (outstanding != '0) && (!rbuf_valid || rsp_ready_i);
  assign r_fire       = obi_rvalid_i && obi_rready_o;
  assign rsp_deq      = rbuf_valid && rsp_ready_i;

  // Request FSM, A-channel registers and the in-flight counter.
  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge value of its neighbours; blocking '=' here
  // would make the result depend on statement order.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state       <= IDLE;
      req_q       <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      outstanding <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_fire) begin
            // wdata is captured for reads as well; the slave ignores it.
            addr_q  <= cmd_addr_i;
            we_q    <= cmd_we_i;
            be_q    <= cmd_be_i;
            wdata_q <= cmd_wdata_i;
            req_q   <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          // req is never withdrawn: wait for the grant however long it takes.
          if (obi_gnt_i) begin
            req_q <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          req_q <= 1'b0;
          state <= IDLE;
        end
      endcase

      // A grant and a response in the same cycle cancel out.
      unique case ({gnt_fire, r_fire})
        2'b10:   outstanding <= outstanding + CNT_WIDTH'(1);
        2'b01:   outstanding <= outstanding - CNT_WIDTH'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // One-entry response buffer and error counter.
  // NOTE: the buffered payload is reset along with its valid bit so the
  // response outputs read zero after reset rather than stale data.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rbuf_valid <= 1'b0;
      rbuf_rdata <= '0;
      rbuf_err   <= 1'b0;
      err_count  <= '0;
    end else begin
      if (r_fire) begin
        // Capture wins over dequeue: a drain and refill in the same cycle
        // leaves the buffer full with the new response.
        rbuf_valid <= 1'b1;
        rbuf_rdata <= obi_rdata_i;
        rbuf_err   <= obi_err_i;
        if (obi_err_i && (err_count != 16'hFFFF)) begin
          err_count <= err_count + 16'd1;
        end
      end else if (rsp_deq) begin
        rbuf_valid <= 1'b0;
      end
    end
  end

  assign obi_req_o   = req_q;
  assign obi_addr_o  = addr_q;
  assign obi_we_o    = we_q;
  assign obi_be_o    = be_q;
  assign obi_wdata_o = wdata_q;

  assign rsp_valid_o = rbuf_valid;
  assign rsp_rdata_o = rbuf_rdata;
  assign rsp_err_o   = rbuf_err;

  assign busy_o      = (state == REQ) || (outstanding != '0) || rbuf_valid;
  assign err_count_o = err_count;

endmodule

// File: tb/tb_obi_master.sv
// Testbench for obi_master. Contains a small behavioural OBI slave (word
// memory indexed by addr[5:2], error response for address 0xFFFF_FFFF,
// in-order response queue) plus table-driven single transactions and
// hand-written sequences for backpressure, unsolicited responses and a
// grant stall interrupted by reset.
module tb_obi_master;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b1;

  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [31:0] cmd_addr_i = '0;
  logic        cmd_we_i = 1'b0;
  logic [3:0]  cmd_be_i = '0;
  logic [31:0] cmd_wdata_i = '0;

  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  logic        obi_req_o;
  logic        obi_gnt_i;
  logic [31:0] obi_addr_o;
  logic        obi_we_o;
  logic [3:0]  obi_be_o;
  logic [31:0] obi_wdata_o;

  logic        obi_rvalid_i;
  logic        obi_rready_o;
  logic [31:0] obi_rdata_i;
  logic        obi_err_i;

  logic        busy_o;
  logic [15:0] err_count_o;

  obi_master #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_we_i     (cmd_we_i),
    .cmd_be_i     (cmd_be_i),
    .cmd_wdata_i  (cmd_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .obi_req_o    (obi_req_o),
    .obi_gnt_i    (obi_gnt_i),
    .obi_addr_o   (obi_addr_o),
    .obi_we_o     (obi_we_o),
    .obi_be_o     (obi_be_o),
    .obi_wdata_o  (obi_wdata_o),
    .obi_rvalid_i (obi_rvalid_i),
    .obi_rready_o (obi_rready_o),
    .obi_rdata_i  (obi_rdata_i),
    .obi_err_i    (obi_err_i),
    .busy_o       (busy_o),
    .err_count_o  (err_count_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural OBI slave ----------------
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } slv_rsp_t;

  logic [31:0] mem [16];
  slv_rsp_t    rsp_q [$];
  logic        gnt_en    = 1'b1;
  logic        rvalid_en = 1'b1;
  logic        force_rv  = 1'b0;
  logic        slv_rv    = 1'b0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err   = 1'b0;
  int          gnt_count = 0;
  logic [31:0] last_addr  = '0;
  logic        last_we    = 1'b0;
  logic [3:0]  last_be    = '0;
  logic [31:0] last_wdata = '0;

  assign obi_gnt_i    = gnt_en;
  assign obi_rvalid_i = slv_rv | force_rv;
  assign obi_rdata_i  = force_rv ? 32'hDEAD_DEAD : slv_rdata;
  assign obi_err_i    = force_rv ? 1'b1 : slv_err;

  always @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rsp_q.delete();
      slv_rv    = 1'b0;
      slv_rdata = '0;
      slv_err   = 1'b0;
    end else begin
      if (obi_req_o && obi_gnt_i) begin
        slv_rsp_t r;
        logic [3:0] idx;
        gnt_count++;
        last_addr  = obi_addr_o;
        last_we    = obi_we_o;
        last_be    = obi_be_o;
        last_wdata = obi_wdata_o;
        idx = obi_addr_o[5:2];
        if (obi_addr_o == 32'hFFFF_FFFF) begin
          r.rdata = 32'hBADC_AB1E;
          r.err   = 1'b1;
        end else if (obi_we_o) begin
          for (int b = 0; b < 4; b++) begin
            if (obi_be_o[b]) mem[idx][8*b +: 8] = obi_wdata_o[8*b +: 8];
          end
          r.rdata = '0;
          r.err   = 1'b0;
        end else begin
          r.rdata = mem[idx];
          r.err   = 1'b0;
        end
        rsp_q.push_back(r);
      end
      if (slv_rv && obi_rready_o && !force_rv) void'(rsp_q.pop_front());
      #1;
      slv_rv    = rvalid_en && (rsp_q.size() != 0);
      slv_rdata = (rsp_q.size() != 0) ? rsp_q[0].rdata : '0;
      slv_err   = (rsp_q.size() != 0) ? rsp_q[0].err : 1'b0;
    end
  end

  // ---------------- controller-side helpers ----------------
  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input int max_cyc, output bit ok);
    bit rdy;
    ok          = 1'b0;
    cmd_we_i    = we;
    cmd_addr_i  = addr;
    cmd_be_i    = be;
    cmd_wdata_i = wdata;
    cmd_valid_i = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      rdy = cmd_ready_o;
      @(posedge clk_i);
      @(negedge clk_i);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    cmd_valid_i = 1'b0;
  endtask

  // Counts negedges until rsp_valid_o is seen (0 = already valid).
  task automatic wait_rsp(output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
      cyc++;
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input vec_t v);
    bit ok;
    int cyc;
    send_cmd(v.we, v.addr, v.be, v.wdata, 10, ok);
    check("cmd_accepted", 32'(ok), 32'd1);
    check("req_after_accept", 32'(obi_req_o), 32'd1);
    check("ready_low_in_req", 32'(cmd_ready_o), 32'd0);
    wait_rsp(ok, cyc);
    check("rsp_seen", 32'(ok), 32'd1);
    check("rsp_latency", 32'(cyc), 32'd2);
    check("rsp_rdata", rsp_rdata_o, v.exp_rdata);
    check("rsp_err", 32'(rsp_err_o), 32'(v.exp_err));
    check("obi_addr", last_addr, v.addr);
    check("obi_we", 32'(last_we), 32'(v.we));
    check("obi_be", 32'(last_be), 32'(v.be));
    check("obi_wdata", last_wdata, v.wdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int gnt_base;
    logic [31:0] bp_exp_rdata [3];
    logic        bp_exp_err   [3];
    int k;

    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[1] = 32'hDA7A_5EAD;
    mem[5] = 32'h1122_3344;

    vecs[0] = '{we: 1'b0, addr: 32'h0000_0004, be: 4'hF, wdata: 32'h0BAD_F00D, exp_rdata: 32'hDA7A_5EAD, exp_err: 1'b0};
    vecs[1] = '{we: 1'b1, addr: 32'h0000_0002, be: 4'hF, wdata: 32'h1337_C0DE, exp_rdata: 32'h0000_0000, exp_err: 1'b0};
    vecs[2] = '{we: 1'b0, addr: 32'hFFFF_FFFF, be: 4'hF, wdata: 32'h0000_0000, exp_rdata: 32'hBADC_AB1E, exp_err: 1'b1};
    vecs[3] = '{we: 1'b1, addr: 32'h0000_0010, be: 4'hF, wdata: 32'hCAFE_F00D, exp_rdata: 32'h0000_0000, exp_err: 1'b0};
    vecs[4] = '{we: 1'b0, addr: 32'h0000_0010, be: 4'hF, wdata: 32'h5555_AAAA, exp_rdata: 32'hCAFE_F00D, exp_err: 1'b0};
    vecs[5] = '{we: 1'b1, addr: 32'h0000_0014, be: 4'h3, wdata: 32'hAABB_CCDD, exp_rdata: 32'h0000_0000, exp_err: 1'b0};
    vecs[6] = '{we: 1'b0, addr: 32'h0000_0014, be: 4'hF, wdata: 32'h0000_0001, exp_rdata: 32'h1122_CCDD, exp_err: 1'b0};

    // Power-on reset pulse.
    #2 reset_ni = 1'b0;
    #5 reset_ni = 1'b1;
    @(negedge clk_i);
    check("rst_req", 32'(obi_req_o), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    check("rst_err_count", 32'(err_count_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_rready", 32'(obi_rready_o), 32'd0);
    check("rst_addr", obi_addr_o, 32'd0);
    check("rst_rdata", rsp_rdata_o, 32'd0);

    // Single transactions with immediate grant and response.
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);
    @(negedge clk_i);
    check("err_count_after_table", 32'(err_count_o), 32'd1);
    check("idle_after_table", 32'(busy_o), 32'd0);

    // Backpressure: no responses drain, so only two transactions issue.
    rsp_ready_i = 1'b0;
    rvalid_en   = 1'b0;
    gnt_base    = gnt_count;
    bp_exp_rdata[0] = 32'hDA7A_5EAD; bp_exp_err[0] = 1'b0;
    bp_exp_rdata[1] = 32'hCAFE_F00D; bp_exp_err[1] = 1'b0;
    bp_exp_rdata[2] = 32'hBADC_AB1E; bp_exp_err[2] = 1'b1;
    send_cmd(1'b0, 32'h0000_0004, 4'hF, 32'h0, 10, ok);
    check("bp_accept0", 32'(ok), 32'd1);
    send_cmd(1'b0, 32'h0000_0010, 4'hF, 32'h0, 10, ok);
    check("bp_accept1", 32'(ok), 32'd1);
    @(negedge clk_i);
    @(negedge clk_i);
    check("bp_grants", 32'(gnt_count - gnt_base), 32'd2);
    check("bp_cmd_ready", 32'(cmd_ready_o), 32'd0);
    check("bp_busy", 32'(busy_o), 32'd1);
    check("bp_req_low", 32'(obi_req_o), 32'd0);
    k = 0;
    fork
      begin
        bit ok3;
        send_cmd(1'b0, 32'hFFFF_FFFF, 4'hF, 32'h0, 40, ok3);
        check("bp_accept2", 32'(ok3), 32'd1);
      end
      begin
        // Hold the third command pending for a few cycles before draining.
        for (int i = 0; i < 3; i++) @(negedge clk_i);
        check("bp_third_blocked", 32'(gnt_count - gnt_base), 32'd2);
        rsp_ready_i = 1'b1;
        rvalid_en   = 1'b1;
        for (int i = 0; i < 60 && k < 3; i++) begin
          if (rsp_valid_o) begin
            check($sformatf("bp_rdata%0d", k), rsp_rdata_o, bp_exp_rdata[k]);
            check($sformatf("bp_err%0d", k), 32'(rsp_err_o), 32'(bp_exp_err[k]));
            k++;
          end
          @(negedge clk_i);
        end
      end
    join
    check("bp_rsp_count", 32'(k), 32'd3);
    for (int i = 0; i < 3; i++) @(negedge clk_i);
    check("bp_drained_busy", 32'(busy_o), 32'd0);
    check("bp_drained_ready", 32'(cmd_ready_o), 32'd1);
    check("bp_err_count", 32'(err_count_o), 32'd2);

    // Unsolicited rvalid with nothing outstanding is ignored.
    force_rv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("unsol_rready", 32'(obi_rready_o), 32'd0);
      check("unsol_rsp_valid", 32'(rsp_valid_o), 32'd0);
    end
    force_rv = 1'b0;
    check("unsol_err_count", 32'(err_count_o), 32'd2);

    // Grant stall: req and payload must hold, then reset clears everything.
    gnt_en = 1'b0;
    send_cmd(1'b0, 32'h0000_0020, 4'hF, 32'h0, 10, ok);
    check("stall_accept", 32'(ok), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("stall_req", 32'(obi_req_o), 32'd1);
      check("stall_addr", obi_addr_o, 32'h0000_0020);
      @(negedge clk_i);
    end
    #2 reset_ni = 1'b0;
    #1;
    check("mid_rst_req", 32'(obi_req_o), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_err_count", 32'(err_count_o), 32'd0);
    check("mid_rst_addr", obi_addr_o, 32'd0);
    #5 reset_ni = 1'b1;
    gnt_en = 1'b1;
    @(negedge clk_i);

    // Normal operation resumes after reset.
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
